// File: rtl/main_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_pkg
// Purpose  : Shared types and constants for the main_memory responder.
//            - FSM state encoding (IDLE, BUSY, ACK, DONE)
//            - word size and byte-offset width of the word-addressed array
//            - width of the latency down-counter
// Revision : 1.0 - initial release
// ============================================================================
package main_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int c_word_bytes       = 4;
    localparam int c_byte_offset_bits = 2;
    localparam int c_cnt_bits         = 8;

endpackage
`default_nettype wire

// File: rtl/main_memory_ram.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_ram
// Purpose  : Single-port synchronous RAM, 32 bits x 2^ADDR_BITS words, with
//            write enable and a one-cycle registered read. The read register
//            only updates when re is high, so it holds its value between reads.
// Ports    : clk, reset (sync, clears read register only), we, re, addr,
//            wdata, rdata
// Revision : 1.0 - initial release
// ============================================================================
module main_memory_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] r_mem [0:(1<<ADDR_BITS)-1];

    // Array has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= r_mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module   : main_memory
// Purpose  : Fixed-latency, one-access-at-a-time memory responder for the CPU
//            external memory port. A request seen in IDLE at cycle T is acked
//            at T+LATENCY; one dead cycle (DONE) follows the ack.
// Ports    : clk, reset (sync, active-high), mem_read, mem_write, mem_addr,
//            mem_write_data, mem_ack, mem_read_data, mem_err (optional)
// Macro    : MAIN_MEMORY_ALIGN_CHECK_EN - adds mem_err; misaligned or
//            out-of-range accesses ack with mem_err=1, writes are dropped and
//            reads return 0. Without it, low and high address bits are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module main_memory
    import main_memory_pkg::*;
#(
    parameter int          ADDR_BITS = 12,
    parameter int          LATENCY   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic        mem_ack,
    output logic [31:0] mem_read_data
`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    ,
    output logic        mem_err
`endif
);

    state_t                  r_state;
    logic [c_cnt_bits-1:0]   r_cnt;
    logic                    r_write;
    logic [ADDR_BITS-1:0]    r_idx;
    logic [31:0]             r_wdata;
    logic                    r_err;
    logic                    r_ack;
    logic                    r_err_out;

    logic [31:0]             w_offset;
    logic [ADDR_BITS-1:0]    w_live_idx;
    logic                    w_live_err;
    logic                    w_req;
    logic                    w_accept;
    logic                    w_enter_ack;
    logic                    w_op_write;
    logic [ADDR_BITS-1:0]    w_op_idx;
    logic [31:0]             w_op_data;
    logic                    w_op_err;
    logic                    w_ram_we;
    logic                    w_ram_re;
    logic [31:0]             w_ram_rdata;

    assign w_offset   = mem_addr - BASE_ADDR;
    assign w_live_idx = w_offset[ADDR_BITS+c_byte_offset_bits-1:c_byte_offset_bits];
    assign w_req      = mem_read | mem_write;
    assign w_accept   = (r_state == IDLE) && w_req;

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    assign w_live_err = (w_offset[c_byte_offset_bits-1:0] != '0) ||
                        (w_offset >= 32'(c_word_bytes << ADDR_BITS));
`else
    logic w_unused_bits;
    assign w_live_err    = 1'b0;
    assign w_unused_bits = &{1'b0, w_offset[c_byte_offset_bits-1:0],
                             w_offset[31:ADDR_BITS+c_byte_offset_bits], r_err_out};
`endif

    // The array is touched on the edge that enters ACK. With LATENCY==1 that
    // edge is the acceptance edge, so the operands come from the live inputs.
    assign w_enter_ack = (LATENCY == 1) ? w_accept
                                        : ((r_state == BUSY) && (r_cnt == c_cnt_bits'(1)));
    assign w_op_write  = (LATENCY == 1) ? mem_write      : r_write;
    assign w_op_idx    = (LATENCY == 1) ? w_live_idx     : r_idx;
    assign w_op_data   = (LATENCY == 1) ? mem_write_data : r_wdata;
    assign w_op_err    = (LATENCY == 1) ? w_live_err     : r_err;

    // Reset has priority: an access interrupted by reset never commits.
    assign w_ram_we = w_enter_ack &&  w_op_write && !w_op_err && !reset;
    assign w_ram_re = w_enter_ack && !w_op_write && !reset;

    main_memory_ram #(
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_ram_we),
        .re    (w_ram_re),
        .addr  (w_op_idx),
        .wdata (w_op_data),
        .rdata (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_write   <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_err     <= 1'b0;
            r_ack     <= 1'b0;
            r_err_out <= 1'b0;
        end else begin
            r_ack     <= 1'b0;
            r_err_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        // Write wins when both request lines are high.
                        r_write <= mem_write;
                        r_idx   <= w_live_idx;
                        r_wdata <= mem_write_data;
                        r_err   <= w_live_err;
                        r_cnt   <= c_cnt_bits'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            r_state   <= ACK;
                            r_ack     <= 1'b1;
                            r_err_out <= w_live_err;
                        end else begin
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt - c_cnt_bits'(1);
                    if (r_cnt == c_cnt_bits'(1)) begin
                        r_state   <= ACK;
                        r_ack     <= 1'b1;
                        r_err_out <= r_err;
                    end
                end
                ACK:     r_state <= DONE;
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_ack = r_ack;

`ifdef MAIN_MEMORY_ALIGN_CHECK_EN
    // Erroring reads report zero until the next read completes.
    logic r_rd_zero;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_zero <= 1'b0;
        end else if (w_ram_re) begin
            r_rd_zero <= w_op_err;
        end
    end
    assign mem_read_data = r_rd_zero ? 32'h0 : w_ram_rdata;
    assign mem_err       = r_err_out;
`else
    assign mem_read_data = w_ram_rdata;
`endif

endmodule
`default_nettype wire
